// File: rtl/my_axi_pkg.sv
// Shared types for the sram-like to AXI3 arbiter.
// Request/response bundles, AXI channel structs, FSM states.
package my_axi_pkg;

  localparam logic [3:0] AXI_LEN   = 4'd0;
  localparam logic [1:0] AXI_BURST = 2'b01;

  typedef struct packed {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
  } sram_rsp_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        valid;
  } axi_ar_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic        last;
    logic        valid;
  } axi_r_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        valid;
  } axi_aw_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic        valid;
  } axi_w_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_AR,
    R_WAIT
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_RESP
  } wr_state_e;

  // Size 3 is not a legal sram size; it behaves as a word.
  function automatic logic [2:0] axsize_f(input logic [1:0] size);
    return (size == 2'd3) ? 3'd2 : {1'b0, size};
  endfunction

  function automatic logic [3:0] wstrb_f(input logic [1:0] size,
                                         input logic [1:0] a);
    case (size)
      2'd0:    return 4'b0001 << a;
      2'd1:    return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/axi_write_ctrl.sv
// Write-channel FSM for the data port.
// Drives AW/W together, waits for B, then reports data_ok.
module axi_write_ctrl
  import my_axi_pkg::*;
#(
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic      clk,
  input  logic      rst,
  input  sram_req_t data_req,
  input  logic      rd_data_busy,
  output logic      wr_addr_ok,
  output logic      wr_data_ok,
  output logic      wr_idle,
  output axi_aw_t   aw,
  input  logic      awready,
  output axi_w_t    w,
  input  logic      wready,
  input  logic      bvalid,
  output logic      bready
);

  wr_state_e   state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        aw_pend_q, aw_pend_d;
  logic        w_pend_q, w_pend_d;

  // State and latched write fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= W_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
    end
  end

  // Accept, AW/W handshakes tracked independently, B response.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    aw_pend_d  = aw_pend_q;
    w_pend_d   = w_pend_q;
    wr_addr_ok = 1'b0;
    wr_data_ok = 1'b0;
    bready     = 1'b0;
    unique case (state_q)
      W_IDLE: begin
        if (data_req.req && data_req.wr && !rd_data_busy) begin
          wr_addr_ok = 1'b1;
          addr_d     = data_req.addr;
          wdata_d    = data_req.wdata;
          size_d     = data_req.size;
          aw_pend_d  = 1'b1;
          w_pend_d   = 1'b1;
          state_d    = W_REQ;
        end
      end
      W_REQ: begin
        if (awready) aw_pend_d = 1'b0;
        if (wready)  w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d) state_d = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          wr_data_ok = 1'b1;
          state_d    = W_IDLE;
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  // AXI write address/data channel fields.
  always_comb begin
    aw       = '0;
    aw.id    = DATA_ID;
    aw.addr  = addr_q;
    aw.size  = axsize_f(size_q);
    aw.valid = aw_pend_q;
    w        = '0;
    w.data   = wdata_q;
    w.strb   = wstrb_f(size_q, addr_q[1:0]);
    w.last   = 1'b1;
    w.valid  = w_pend_q;
  end

  assign wr_idle = (state_q == W_IDLE);

endmodule

// File: rtl/sram_axi_arbiter.sv
// Shares one AXI3 master between inst-fetch and data sram ports.
// Reads arbitrated here (data first); writes in axi_write_ctrl.
module sram_axi_arbiter
  import my_axi_pkg::*;
#(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic      clk,
  input  logic      rst,
  input  sram_req_t inst_req,
  output sram_rsp_t inst_rsp,
  input  sram_req_t data_req,
  output sram_rsp_t data_rsp,
  output axi_ar_t   ar,
  input  logic      arready,
  input  axi_r_t    r,
  output logic      rready,
  output axi_aw_t   aw,
  input  logic      awready,
  output axi_w_t    w,
  input  logic      wready,
  input  logic      bvalid,
  output logic      bready
);

  rd_state_e   rd_state_q, rd_state_d;
  logic [31:0] ar_addr_q, ar_addr_d;
  logic [2:0]  ar_size_q, ar_size_d;
  logic [3:0]  ar_id_q, ar_id_d;

  logic wr_addr_ok, wr_data_ok, wr_idle;
  logic rd_data_busy, data_rd_req;
  logic inst_rd_aok, data_rd_aok;
  logic inst_rd_dok, data_rd_dok;
  logic unused_inst;

  assign unused_inst  = ^{inst_req.wr, inst_req.size, inst_req.wdata};
  assign data_rd_req  = data_req.req && !data_req.wr;
  assign rd_data_busy = (rd_state_q != R_IDLE) && (ar_id_q == DATA_ID);

  axi_write_ctrl #(
    .DATA_ID(DATA_ID)
  ) u_wr (
    .clk          (clk),
    .rst          (rst),
    .data_req     (data_req),
    .rd_data_busy (rd_data_busy),
    .wr_addr_ok   (wr_addr_ok),
    .wr_data_ok   (wr_data_ok),
    .wr_idle      (wr_idle),
    .aw           (aw),
    .awready      (awready),
    .w            (w),
    .wready       (wready),
    .bvalid       (bvalid),
    .bready       (bready)
  );

  // Read FSM state and latched AR fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      ar_addr_q  <= '0;
      ar_size_q  <= '0;
      ar_id_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      ar_addr_q  <= ar_addr_d;
      ar_size_q  <= ar_size_d;
      ar_id_q    <= ar_id_d;
    end
  end

  // Grant (data over inst, data held off during writes), AR, R routing.
  always_comb begin
    rd_state_d  = rd_state_q;
    ar_addr_d   = ar_addr_q;
    ar_size_d   = ar_size_q;
    ar_id_d     = ar_id_q;
    inst_rd_aok = 1'b0;
    data_rd_aok = 1'b0;
    inst_rd_dok = 1'b0;
    data_rd_dok = 1'b0;
    rready      = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        if (data_rd_req && wr_idle) begin
          data_rd_aok = 1'b1;
          ar_addr_d   = data_req.addr;
          ar_size_d   = axsize_f(data_req.size);
          ar_id_d     = DATA_ID;
          rd_state_d  = R_AR;
        end else if (inst_req.req && !wr_addr_ok) begin
          inst_rd_aok = 1'b1;
          ar_addr_d   = inst_req.addr;
          ar_size_d   = 3'd2;
          ar_id_d     = INST_ID;
          rd_state_d  = R_AR;
        end
      end
      R_AR: begin
        if (arready) rd_state_d = R_WAIT;
      end
      R_WAIT: begin
        rready = 1'b1;
        if (r.valid && r.last) begin
          if (r.id == INST_ID) begin
            inst_rd_dok = 1'b1;
            rd_state_d  = R_IDLE;
          end else if (r.id == DATA_ID) begin
            data_rd_dok = 1'b1;
            rd_state_d  = R_IDLE;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Output bundles.
  always_comb begin
    ar               = '0;
    ar.id            = ar_id_q;
    ar.addr          = ar_addr_q;
    ar.size          = ar_size_q;
    ar.valid         = (rd_state_q == R_AR);
    inst_rsp         = '0;
    inst_rsp.addr_ok = inst_rd_aok;
    inst_rsp.data_ok = inst_rd_dok;
    inst_rsp.rdata   = r.data;
    data_rsp         = '0;
    data_rsp.addr_ok = data_rd_aok | wr_addr_ok;
    data_rsp.data_ok = data_rd_dok | wr_data_ok;
    data_rsp.rdata   = r.data;
  end

  a_rid_known: assert property (@(posedge clk) disable iff (rst)
    (rd_state_q == R_WAIT && r.valid) |-> (r.id == INST_ID || r.id == DATA_ID));

endmodule
